// File: rtl/norm_round_pack_f64_if.sv
// Handshake and data bundle between a caller FSM and the float64 normalize/round/pack stage.
// ap_start is sampled only in IDLE; ap_done/ap_ready pulse for one cycle with ap_return valid.
interface norm_round_pack_f64_if #(
    parameter int EXP_W = 16
);
    logic                    ap_start;
    logic                    ap_done;
    logic                    ap_idle;
    logic                    ap_ready;
    logic                    zSign;
    logic signed [EXP_W-1:0] zExp;
    logic [63:0]             zSig;
    logic [63:0]             ap_return;

    modport master (
        output ap_start, zSign, zExp, zSig,
        input  ap_done, ap_idle, ap_ready, ap_return
    );

    modport slave (
        input  ap_start, zSign, zExp, zSig,
        output ap_done, ap_idle, ap_ready, ap_return
    );
endinterface

// File: rtl/norm_round_pack_f64.sv
// Sequential normalizer (one bit per cycle), round-to-nearest-even and IEEE-754 double packer.
// Subnormal results are flushed to signed zero.
module norm_round_pack_f64 #(
    parameter int EXP_W     = 16,
    parameter int MAX_SHIFT = 62
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    norm_round_pack_f64_if.slave  bus,
    output logic [3:0]            dbg_state_o
);
    localparam int CNT_W = $clog2(MAX_SHIFT + 1);
    localparam logic signed [EXP_W-1:0] EXP_TOP = EXP_W'(2045);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_NORM  = 4'b0010,
        S_ROUND = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    state_t                  state_q, state_d;
    logic [63:0]             sig_q, sig_d;
    logic signed [EXP_W-1:0] zexp_q, zexp_d;
    logic                    sign_q, sign_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [63:0]             ret_q, ret_d;

    logic [63:0] inc;
    logic [63:0] r;
    logic [10:0] exp_eff;
    logic        ovf;
    logic        ufl;
    logic [63:0] round_res;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.ap_start) state_d = (bus.zSig == 64'd0) ? S_DONE : S_NORM;
            S_NORM:  if (sig_q[63] || sig_q[62] || cnt_q == CNT_W'(MAX_SHIFT)) state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ap_done  = (state_q == S_DONE);
        bus.ap_ready = (state_q == S_DONE);
        bus.ap_idle  = (state_q == S_IDLE) && !bus.ap_start;
        bus.ap_return = ret_q;
        dbg_state_o  = state_q;
    end

    // Exactly-half remainder (0x200) rounds to even by clearing the LSB after the increment.
    always_comb begin
        inc = sig_q + 64'h200;
        r   = inc >> 10;
        if (sig_q[9:0] == 10'h200) r[0] = 1'b0;
        ovf       = (zexp_q > EXP_TOP) || ((zexp_q == EXP_TOP) && inc[63]);
        ufl       = zexp_q[EXP_W-1];
        exp_eff   = (r == 64'd0) ? 11'd0 : zexp_q[10:0];
        round_res = {sign_q, 63'd0} + ({53'd0, exp_eff} << 52) + r;
        if (ovf)      round_res = {sign_q, 11'h7FF, 52'd0};
        else if (ufl) round_res = {sign_q, 63'd0};
    end

    always_comb begin
        sig_d  = sig_q;
        zexp_d = zexp_q;
        sign_d = sign_q;
        cnt_d  = cnt_q;
        ret_d  = ret_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ap_start) begin
                    sign_d = bus.zSign;
                    zexp_d = bus.zExp;
                    sig_d  = bus.zSig;
                    cnt_d  = '0;
                    if (bus.zSig == 64'd0) ret_d = {bus.zSign, 63'd0};
                end
            end
            S_NORM: begin
                if (sig_q[63]) begin
                    sig_d  = (sig_q >> 1) | {63'd0, sig_q[0]};
                    zexp_d = zexp_q + EXP_W'(1);
                end else if (!sig_q[62] && cnt_q != CNT_W'(MAX_SHIFT)) begin
                    sig_d  = sig_q << 1;
                    zexp_d = zexp_q - EXP_W'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            S_ROUND: ret_d = round_res;
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sig_q  <= '0;
            zexp_q <= '0;
            sign_q <= 1'b0;
            cnt_q  <= '0;
            ret_q  <= '0;
        end else begin
            sig_q  <= sig_d;
            zexp_q <= zexp_d;
            sign_q <= sign_d;
            cnt_q  <= cnt_d;
            ret_q  <= ret_d;
        end
    end
endmodule

// File: tb/tb_norm_round_pack_f64.sv
// Directed-vector bench for norm_round_pack_f64: results, latencies, handshake and reset abort.
module tb_norm_round_pack_f64;
  logic       ap_clk;
  logic       ap_rst_n;
  logic [3:0] dbg_state;

  int n_checks;
  int n_miscompares;
  logic [63:0] exp_q[$];

  norm_round_pack_f64_if #(.EXP_W(16)) bus ();

  norm_round_pack_f64 #(.EXP_W(16), .MAX_SHIFT(62)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs(input logic s, input logic [15:0] e, input logic [63:0] sig);
    bus.zSign = s;
    bus.zExp  = e;
    bus.zSig  = sig;
  endtask

  task automatic run_job(input string tag, input logic s, input logic [15:0] e,
                         input logic [63:0] sig, input logic [63:0] exp_ret, input int exp_lat);
    int   lat;
    logic got;
    logic [63:0] want;
    @(negedge ap_clk);
    drive_inputs(s, e, sig);
    bus.ap_start = 1'b1;
    exp_q.push_back(exp_ret);
    @(posedge ap_clk);
    #1 bus.ap_start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (lat < 200 && !got) begin
      @(negedge ap_clk);
      lat++;
      if (bus.ap_done) got = 1'b1;
    end
    want = exp_q.pop_front();
    check_eq({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_ready"}, 64'(bus.ap_ready), 64'd1);
      check_eq({tag, "_return"}, bus.ap_return, want);
      @(negedge ap_clk);
      check_eq({tag, "_done_pulse"}, 64'(bus.ap_done), 64'd0);
      check_eq({tag, "_return_held"}, bus.ap_return, want);
    end
  endtask

  initial begin
    int   cnt;
    int   done_cnt;
    logic got;
    n_checks      = 0;
    n_miscompares = 0;
    bus.ap_start  = 1'b0;
    drive_inputs(1'b0, 16'h0000, 64'd0);
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    check_eq("rst_idle",   64'(bus.ap_idle),  64'd1);
    check_eq("rst_done",   64'(bus.ap_done),  64'd0);
    check_eq("rst_ready",  64'(bus.ap_ready), 64'd0);
    check_eq("rst_return", bus.ap_return,     64'd0);
    check_eq("rst_state",  64'(dbg_state),    64'h1);
    ap_rst_n = 1'b1;

    run_job("one",       1'b0, 16'h03FE, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3);
    run_job("max_shift", 1'b1, 16'h043C, 64'h0000_0000_0000_0001, 64'hBFF0_0000_0000_0000, 65);
    run_job("tie_even",  1'b0, 16'h03FE, 64'h4000_0000_0000_0200, 64'h3FF0_0000_0000_0000, 3);
    run_job("tie_odd",   1'b0, 16'h03FE, 64'h4000_0000_0000_0600, 64'h3FF0_0000_0000_0002, 3);
    run_job("round_up",  1'b0, 16'h03FE, 64'h4000_0000_0000_0201, 64'h3FF0_0000_0000_0001, 3);
    run_job("overflow",  1'b0, 16'h07FE, 64'h4000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 3);
    run_job("ovf_carry", 1'b1, 16'h07FD, 64'h7FFF_FFFF_FFFF_FE00, 64'hFFF0_0000_0000_0000, 3);
    run_job("zero",      1'b1, 16'h0123, 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 1);
    run_job("underflow", 1'b1, 16'hFFFF, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 3);
    run_job("right_sh",  1'b0, 16'h03FD, 64'h8000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3);
    run_job("shift3",    1'b0, 16'h0401, 64'h0800_0000_0000_0000, 64'h3FF0_0000_0000_0000, 6);

    // reset in the middle of a long normalization
    @(negedge ap_clk);
    drive_inputs(1'b1, 16'h043C, 64'd1);
    bus.ap_start = 1'b1;
    @(posedge ap_clk);
    #1 bus.ap_start = 1'b0;
    repeat (10) @(negedge ap_clk);
    check_eq("abort_in_norm", 64'(dbg_state), 64'h2);
    ap_rst_n = 1'b0;
    #1;
    check_eq("abort_idle",   64'(bus.ap_idle), 64'd1);
    check_eq("abort_return", bus.ap_return,    64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    done_cnt = 0;
    repeat (80) begin
      @(negedge ap_clk);
      if (bus.ap_done) done_cnt++;
    end
    check_eq("abort_no_done",  64'(done_cnt),      64'd0);
    check_eq("abort_idle_end", 64'(bus.ap_idle),   64'd1);
    check_eq("abort_ret_end",  bus.ap_return,      64'd0);

    // start held high across DONE: back-to-back jobs, result held between them
    @(negedge ap_clk);
    drive_inputs(1'b0, 16'h03FE, 64'h4000_0000_0000_0000);
    bus.ap_start = 1'b1;
    cnt = 0;
    got = 1'b0;
    while (cnt < 50 && !got) begin
      @(negedge ap_clk);
      cnt++;
      if (bus.ap_done) got = 1'b1;
    end
    check_eq("held_a_done", 64'(got), 64'd1);
    check_eq("held_a_ret",  bus.ap_return, 64'h3FF0_0000_0000_0000);
    drive_inputs(1'b0, 16'h03FE, 64'h4000_0000_0000_0600);
    @(negedge ap_clk);
    check_eq("held_idle_state", 64'(dbg_state),   64'h1);
    check_eq("held_idle_low",   64'(bus.ap_idle), 64'd0);
    check_eq("held_ret_idle",   bus.ap_return,    64'h3FF0_0000_0000_0000);
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    check_eq("held_b_norm",     64'(dbg_state),   64'h2);
    check_eq("held_ret_norm",   bus.ap_return,    64'h3FF0_0000_0000_0000);
    cnt = 0;
    got = 1'b0;
    while (cnt < 50 && !got) begin
      @(negedge ap_clk);
      cnt++;
      if (bus.ap_done) got = 1'b1;
    end
    check_eq("held_b_done", 64'(got), 64'd1);
    check_eq("held_b_ret",  bus.ap_return, 64'h3FF0_0000_0000_0002);
    @(negedge ap_clk);
    check_eq("held_b_idle", 64'(bus.ap_idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end
endmodule

// File: doc/norm_round_pack_f64.md
Name: norm_round_pack_f64

Overview:
- Callee-side (responder) float64 unit implementing the ap_ctrl_hs handshake, the protocol our top-level FSMs use to drive sub-functions.
- Takes sign, exponent and an unnormalized 64-bit significand, and returns a packed IEEE-754 double.
- Normalizes sequentially, one bit per cycle, then rounds to nearest-even and packs.
- Sits under the float64 add/sub cores as their shared final stage.

Parameters:
- EXP_W, 16, width of signed two's-complement zExp input.
- MAX_SHIFT, 62, maximum left-normalization steps (guard against runaway).

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  request; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse, result valid.
- ap_idle  out  1  high in IDLE while ap_start low.
- ap_ready  out  1  identical to ap_done; inputs may change after it.
- zSign  in  1  result sign.
- zExp  in  EXP_W  biased exponent minus one (softfloat convention).
- zSig  in  64  significand; binary point between bits 62 and 61.
- ap_return  out  64  packed double; held until the next accepted start.

Behaviour:
- Reset:
  - Asynchronous on ap_rst_n low: state=IDLE, ap_return=0, internal sig/exp/sign=0.
  - ap_done=ap_ready=0; ap_idle=1 if ap_start low.
  - Reset mid-operation aborts the job; no ap_done is produced.
- States: IDLE, NORM, ROUND, DONE (one-hot).
- IDLE:
  - If ap_start=1, capture zSign, zExp and zSig on that edge.
  - If zSig==0, go to DONE with ap_return={zSign,63'b0}.
  - Otherwise go to NORM.
- NORM, each cycle:
  - If sig[63]=1: sig=(sig>>1)|sticky(sig[0]), exp=exp+1, go to ROUND.
  - Else if sig[62]=1: go to ROUND.
  - Else: sig=sig<<1, exp=exp-1, stay in NORM.
  - The step counter saturates at MAX_SHIFT; reaching it forces ROUND. Unreachable for nonzero input.
- ROUND, single cycle, result written to ap_return:
  - rb=sig[9:0]; inc=sig+0x200; r=inc>>10; if rb==0x200, clear r[0].
  - Overflow: exp>0x7FD as signed, or (exp==0x7FD and inc[63]=1), gives ap_return={zSign,11'h7FF,52'b0}.
  - Underflow: exp<0 as signed flushes to {zSign,63'b0}. This is a documented deviation: no subnormals.
  - If r==0, exp is treated as 0.
  - Otherwise ap_return=({zSign,63'b0}) + (exp[10:0]<<52) + r, a 64-bit add. The hidden bit carries into the exponent.
  - Go to DONE.
- DONE:
  - ap_done=ap_ready=1, combinational on state; next state IDLE.
  - ap_start during DONE is ignored; it is accepted in IDLE on the following cycle.
- Latency from the start-sampling edge to the ap_done cycle:
  - Normalized input: 3 cycles.
  - Each left shift adds 1 cycle.
  - zSig==0: 1 cycle.
- ap_idle is combinational: (state==IDLE)&~ap_start.
- Inputs are ignored outside IDLE.

Test Plan:
- Already normalized: zSign=0, zExp=0x3FE, zSig=0x4000_0000_0000_0000 -> ap_return=0x3FF0_0000_0000_0000, ap_done 3 cycles after start, single-cycle pulse, ap_ready coincident.
- Max shift: zSign=1, zExp=0x43C, zSig=1 -> ap_return=0xBFF0_0000_0000_0000, ap_done 65 cycles after start.
- Ties-to-even:
  - zExp=0x3FE, zSig=0x4000_0000_0000_0200 -> 0x3FF0_0000_0000_0000.
  - zSig=0x4000_0000_0000_0600 -> 0x3FF0_0000_0000_0002.
- Boundaries:
  - zExp=0x7FE, zSig=0x4000_0000_0000_0000 -> 0x7FF0_0000_0000_0000.
  - zSign=1, zSig=0 -> 0x8000_0000_0000_0000, ap_done 1 cycle after start.
  - zExp=0xFFFF (-1) -> signed zero.
- Right-shift path: zExp=0x3FD, zSig=0x8000_0000_0000_0000 -> 0x3FF0_0000_0000_0000, 3-cycle latency.
- Handshake/reset:
  - Deassert ap_rst_n during NORM -> ap_done never pulses, ap_idle=1 once ap_start is low, ap_return=0.
  - ap_start held high across DONE -> next job starts from IDLE, ap_return held between jobs.
